// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: miss sequencer for the 2-way write-back data cache (victim write-back, block fill, refill strobe).
// Optional feature macro: CACHE_PERF_EN adds miss / write-back / stall-cycle performance counters.
module cache_miss_ctrl #(
    parameter int BLOCK_W    = 128,
    parameter int REFILL_CNT = 20,
    parameter int PERF_W     = 32
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_access,
    input  logic               i_write,
    input  logic               i_hit,
    input  logic [17:0]        i_tag,
    input  logic [9:0]         i_set,
    input  logic [17:0]        i_miss_tag,
    input  logic [BLOCK_W-1:0] i_victim_data,
    input  logic               i_victim_valid,
    input  logic               i_victim_dirty,
    output logic               o_stall,
    output logic [4:0]         o_stall_count,
    output logic [BLOCK_W-1:0] o_replace_data,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [31:0]        o_mem_addr,
    output logic [BLOCK_W-1:0] o_mem_wdata,
`ifdef CACHE_PERF_EN
    output logic [PERF_W-1:0]  o_miss_cnt,
    output logic [PERF_W-1:0]  o_wb_cnt,
    output logic [PERF_W-1:0]  o_stall_cyc_cnt,
`endif
    input  logic               i_mem_ack,
    input  logic [BLOCK_W-1:0] i_mem_rdata
);
    typedef enum logic [2:0] {IDLE, WB, FILL, REFILL, RESUME} state_t;
    state_t             r_state, w_next;
    logic [17:0]        r_tag;
    logic [9:0]         r_set;
    logic               r_write;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [BLOCK_W-1:0] r_mem_wdata;
    logic [BLOCK_W-1:0] r_replace_data;
    logic               w_miss;
    logic               w_dirty;
    logic               w_ack;
    // The store flag is captured for completeness; the merge itself happens in the cache on replay.
    logic               w_unused;
    assign w_unused = r_write;
    assign w_miss  = (r_state == IDLE) & i_access & ~i_hit;
    assign w_dirty = i_victim_valid & i_victim_dirty;
    assign w_ack   = r_mem_req & i_mem_ack;
    assign o_mem_req      = r_mem_req;
    assign o_mem_we       = r_mem_we;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_wdata    = r_mem_wdata;
    assign o_replace_data = r_replace_data;
    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    // Next state plus combinational stall and refill strobe.
    always_comb begin
        w_next        = r_state;
        o_stall       = (r_state != IDLE) | w_miss;
        o_stall_count = (r_state == REFILL) ? 5'(REFILL_CNT) : 5'd0;
        case (r_state)
            IDLE:    w_next = w_miss ? (w_dirty ? WB : FILL) : IDLE;
            WB:      w_next = w_ack ? FILL : WB;
            FILL:    w_next = w_ack ? REFILL : FILL;
            REFILL:  w_next = RESUME;
            default: w_next = IDLE;
        endcase
    end
    // Capture the miss context and run the DRAM handshake; a WB ack drops the request for one cycle before the fill.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tag          <= '0;
            r_set          <= '0;
            r_write        <= 1'b0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_replace_data <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_miss) begin
                    r_tag       <= i_tag;
                    r_set       <= i_set;
                    r_write     <= i_write;
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= w_dirty;
                    r_mem_addr  <= w_dirty ? {i_miss_tag, i_set, 4'b0} : {i_tag, i_set, 4'b0};
                    r_mem_wdata <= i_victim_data;
                end
                WB: if (w_ack) begin
                    r_mem_req  <= 1'b0;
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= {r_tag, r_set, 4'b0};
                end
                FILL: if (!r_mem_req) r_mem_req <= 1'b1;
                else if (w_ack) begin
                    r_mem_req      <= 1'b0;
                    r_replace_data <= i_mem_rdata;
                end
                default: ;
            endcase
        end
    end
`ifdef CACHE_PERF_EN
    // Free-running wrap-around performance counters.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_miss_cnt      <= '0;
            o_wb_cnt        <= '0;
            o_stall_cyc_cnt <= '0;
        end else begin
            o_miss_cnt      <= o_miss_cnt + PERF_W'(w_miss);
            o_wb_cnt        <= o_wb_cnt + PERF_W'(w_miss & w_dirty);
            o_stall_cyc_cnt <= o_stall_cyc_cnt + PERF_W'(o_stall);
        end
    end
`else
    localparam int unused_perf_w = PERF_W;
`endif
endmodule
